// File: rtl/logic_ex_stage.sv
// Logic-unit execute stage: AND/OR/XOR/NOR on 32-bit operands,
// registered toward MEM/WB behind a 2-entry skid buffer.

module and_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a & b;
endmodule

module or_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a | b;
endmodule

module xor_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a ^ b;
endmodule

module nor_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = ~(a | b);
endmodule

module logic_ex_stage (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        FLUSH,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [1:0]  OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  DEST,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] Y,
    output logic        ZERO,
    output logic [4:0]  DEST_OUT
);

    typedef struct packed {
        logic [31:0] y;
        logic        zero;
        logic [4:0]  dest;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t      state_q;
    state_t      state_d;
    entry_t      or_q;
    entry_t      sk_q;
    entry_t      in_entry;
    logic [31:0] y_and;
    logic [31:0] y_or;
    logic [31:0] y_xor;
    logic [31:0] y_nor;
    logic [31:0] res;
    logic        accept;
    logic        drain;
    logic        load_or_in;
    logic        load_or_sk;
    logic        load_sk;

    and_32 u_and (.a(A), .b(B), .y(y_and));
    or_32  u_or  (.a(A), .b(B), .y(y_or));
    xor_32 u_xor (.a(A), .b(B), .y(y_xor));
    nor_32 u_nor (.a(A), .b(B), .y(y_nor));

    always_comb begin
        res = y_and;
        case (OP)
            2'b00:   res = y_and;
            2'b01:   res = y_or;
            2'b10:   res = y_xor;
            2'b11:   res = y_nor;
            default: res = y_and;
        endcase
    end

    assign in_entry = '{y: res, zero: (res == 32'd0), dest: DEST};

    assign IN_READY  = (state_q != TWO);
    assign OUT_VALID = (state_q != EMPTY);
    assign accept    = IN_VALID & IN_READY;
    assign drain     = OUT_VALID & OUT_READY;

    always_comb begin
        state_d    = state_q;
        load_or_in = 1'b0;
        load_or_sk = 1'b0;
        load_sk    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = ONE;
                    load_or_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_d = TWO;
                    load_sk = 1'b1;
                end else if (accept && drain) begin
                    load_or_in = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_d    = ONE;
                    load_or_sk = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash wins: nothing captured this cycle survives.
        if (FLUSH) begin
            state_d    = EMPTY;
            load_or_in = 1'b0;
            load_or_sk = 1'b0;
            load_sk    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= EMPTY;
            or_q    <= '0;
            sk_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load_or_in) begin
                or_q <= in_entry;
            end else if (load_or_sk) begin
                or_q <= sk_q;
            end
            if (load_sk) begin
                sk_q <= in_entry;
            end
        end
    end

    assign Y        = or_q.y;
    assign ZERO     = or_q.zero;
    assign DEST_OUT = or_q.dest;

endmodule

// File: tb/tb_logic_ex_stage.sv
// Directed and random checks for logic_ex_stage.

module tb_logic_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        zero;
    logic [4:0]  dest_out;

    int total;
    int bad;

    typedef struct {
        logic [31:0] y;
        logic        z;
        logic [4:0]  d;
    } exp_t;

    logic_ex_stage dut (
        .CLK(clk),
        .RSTn(rst_n),
        .FLUSH(flush),
        .IN_VALID(in_valid),
        .IN_READY(in_ready),
        .OP(op),
        .A(a),
        .B(b),
        .DEST(dest),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .Y(y),
        .ZERO(zero),
        .DEST_OUT(dest_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        dest = '0;
        #1;
        tick;
        tick;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_hs: valid=%b ready=%b want 0 1",
                     out_valid, in_ready);
        end
        total++;
        if (y !== 32'd0 || zero !== 1'b0 || dest_out !== 5'd0) begin
            bad++;
            $display("FAIL reset_data: y=%h z=%b d=%0d want 0 0 0",
                     y, zero, dest_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_ops;
        logic [31:0] exp_y [4];
        exp_y[0] = 32'h00F0_1234;
        exp_y[1] = 32'hFFF0_FFFF;
        exp_y[2] = 32'hFF00_EDCB;
        exp_y[3] = 32'h000F_0000;
        a = 32'hF0F0_1234;
        b = 32'h0FF0_FFFF;
        dest = 5'd7;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = 2'(i);
            tick;
            total++;
            if (out_valid !== 1'b1 || y !== exp_y[i] || zero !== 1'b0
                || dest_out !== 5'd7 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL op%0d: v=%b y=%h z=%b d=%0d r=%b want 1 %h 0 7 1",
                         i, out_valid, y, zero, dest_out, in_ready, exp_y[i]);
            end
        end
        in_valid = 1'b0;
        tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ops_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_zero;
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 2'b00;
        a = 32'hAAAA_AAAA;
        b = 32'h5555_5555;
        dest = 5'd3;
        tick;
        total++;
        if (out_valid !== 1'b1 || y !== 32'd0 || zero !== 1'b1) begin
            bad++;
            $display("FAIL zero_and: v=%b y=%h z=%b want 1 0 1",
                     out_valid, y, zero);
        end
        op = 2'b11;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        dest = 5'd4;
        tick;
        total++;
        if (out_valid !== 1'b1 || y !== 32'd0 || zero !== 1'b1
            || dest_out !== 5'd4) begin
            bad++;
            $display("FAIL zero_nor: v=%b y=%h z=%b d=%0d want 1 0 1 4",
                     out_valid, y, zero, dest_out);
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_back_pressure;
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 2'b01;
        b = 32'd0;
        dest = 5'd1;
        a = 32'h0000_0100;
        tick;
        total++;
        if (out_valid !== 1'b1 || dest_out !== 5'd1 || in_ready !== 1'b1
            || y !== 32'h0000_0100) begin
            bad++;
            $display("FAIL bp_one: v=%b d=%0d r=%b y=%h want 1 1 1 100",
                     out_valid, dest_out, in_ready, y);
        end
        dest = 5'd2;
        a = 32'h0000_0200;
        tick;
        total++;
        if (in_ready !== 1'b0 || dest_out !== 5'd1) begin
            bad++;
            $display("FAIL bp_two: r=%b d=%0d want 0 1", in_ready, dest_out);
        end
        dest = 5'd3;
        a = 32'h0000_0300;
        tick;
        tick;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || dest_out !== 5'd1
            || y !== 32'h0000_0100) begin
            bad++;
            $display("FAIL bp_hold: r=%b v=%b d=%0d y=%h want 0 1 1 100",
                     in_ready, out_valid, dest_out, y);
        end
        out_ready = 1'b1;
        tick;
        total++;
        if (out_valid !== 1'b1 || dest_out !== 5'd2 || y !== 32'h0000_0200
            || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second: v=%b d=%0d y=%h r=%b want 1 2 200 1",
                     out_valid, dest_out, y, in_ready);
        end
        tick;
        total++;
        if (out_valid !== 1'b1 || dest_out !== 5'd3 || y !== 32'h0000_0300) begin
            bad++;
            $display("FAIL bp_third: v=%b d=%0d y=%h want 1 3 300",
                     out_valid, dest_out, y);
        end
        in_valid = 1'b0;
        tick;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_empty: v=%b r=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 2'b10;
        a = 32'h1234_5678;
        b = 32'd0;
        dest = 5'd4;
        tick;
        dest = 5'd5;
        tick;
        flush = 1'b1;
        dest = 5'd9;
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_two: v=%b r=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick;
        tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_ghost: v=%b d=%0d want v=0", out_valid, dest_out);
        end
        out_ready = 1'b0;
        in_valid = 1'b1;
        dest = 5'd10;
        tick;
        flush = 1'b1;
        dest = 5'd11;
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_one: v=%b r=%b want 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        dest = 5'd12;
        a = 32'h0000_00C0;
        tick;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || dest_out !== 5'd12 || y !== 32'h0000_00C0
            || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_after: v=%b d=%0d y=%h r=%b want 1 12 c0 1",
                     out_valid, dest_out, y, in_ready);
        end
        out_ready = 1'b1;
        tick;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 2'b01;
        a = 32'hDEAD_0000;
        b = 32'h0000_BEEF;
        dest = 5'd13;
        tick;
        dest = 5'd14;
        tick;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || y !== 32'd0 || in_ready !== 1'b1
            || dest_out !== 5'd0 || zero !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: v=%b y=%h r=%b d=%0d z=%b want 0 0 1 0 0",
                     out_valid, y, in_ready, dest_out, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        op = 2'b00;
        a = 32'h0000_FFFF;
        b = 32'h0F0F_0F0F;
        dest = 5'd15;
        tick;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || y !== 32'h0000_0F0F || dest_out !== 5'd15
            || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_recover: v=%b y=%h d=%0d r=%b want 1 f0f 15 1",
                     out_valid, y, dest_out, in_ready);
        end
        out_ready = 1'b1;
        tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_recover_empty: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_soak;
        exp_t q[$];
        exp_t e;
        logic acc;
        logic drn;
        for (int n = 0; n < 10000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) == 0);
            op        = 2'($urandom_range(0, 3));
            a         = $urandom;
            b         = ($urandom_range(0, 7) == 0) ? ~a : $urandom;
            dest      = 5'($urandom_range(0, 31));
            case (op)
                2'b00: e.y = a & b;
                2'b01: e.y = a | b;
                2'b10: e.y = a ^ b;
                default: e.y = ~(a | b);
            endcase
            e.z = (e.y == 32'd0);
            e.d = dest;
            acc = in_valid && (q.size() < 2);
            drn = out_ready && (q.size() > 0);
            tick;
            if (flush) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            total++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                bad++;
                $display("FAIL soak_hs@%0d: v=%b r=%b want occupancy %0d",
                         n, out_valid, in_ready, q.size());
            end
            if (q.size() > 0) begin
                total++;
                if (y !== q[0].y || zero !== q[0].z || dest_out !== q[0].d) begin
                    bad++;
                    $display("FAIL soak_data@%0d: y=%h z=%b d=%0d want %h %b %0d",
                             n, y, zero, dest_out, q[0].y, q[0].z, q[0].d);
                end
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_basic_ops;
        test_zero;
        test_back_pressure;
        test_flush;
        test_async_reset;
        test_soak;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_ex_stage.md
# logic_ex_stage

Registered execute stage for the 32-bit logic unit of the MIPS datapath. It accepts operand pairs and a 2-bit logic opcode from the ID/EX boundary and computes AND, OR, XOR or NOR using the bit-wise gate modules (`and_32` and siblings). It registers the result, a zero flag and the destination register number toward the MEM/WB side. A 2-entry skid buffer sustains one operation per cycle under valid/ready back-pressure.

## Interface
- No parameters; datapath is fixed at 32 bits, destination field at 5 bits.
- CLK  input  1  single clock; all state updates on rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- FLUSH  input  1  synchronous pipeline flush (branch/exception squash).
- IN_VALID  input  1  upstream presents an operation.
- IN_READY  output  1  stage can accept an operation this cycle.
- OP  input  2  logic opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
- A  input  32  operand A.
- B  input  32  operand B.
- DEST  input  5  destination register number, carried unchanged.
- OUT_VALID  output  1  result entry is valid.
- OUT_READY  input  1  downstream accepts the result this cycle.
- Y  output  32  registered result.
- ZERO  output  1  1 when Y == 0.
- DEST_OUT  output  5  destination of the presented result.

## Operation
- Result function: Y = A&B, A|B, A^B or ~(A|B) per OP. Evaluation is combinational on the input side and is captured at acceptance.
- The captured entry is {Y, ZERO, DEST}, 38 bits. ZERO is computed before capture.
- Storage: output register (OR) drives the outputs; skid register (SK) holds one overflow entry.
- States:
  - EMPTY: OR invalid, SK invalid.
  - ONE: OR valid, SK invalid.
  - TWO: OR valid, SK valid.
- Definitions: IN_READY = (state != TWO). Accept = IN_VALID & IN_READY. Drain = OUT_VALID & OUT_READY.
- Transitions without FLUSH:
  - EMPTY: accept → ONE, entry into OR.
  - ONE: accept without drain → TWO, entry into SK. Accept with drain → ONE, entry into OR. Drain only → EMPTY.
  - TWO: drain → ONE, SK moves to OR. Otherwise hold. No accept is possible in TWO.
- Ordering is strictly FIFO. No entry is duplicated or dropped.
- FLUSH = 1: next state is EMPTY regardless of accept or drain. An operation accepted in the same cycle is discarded. A drain in the same cycle still counts as consumed downstream.
- OUT_VALID = (state != EMPTY). Y, ZERO and DEST_OUT reflect OR.
- Y, ZERO and DEST_OUT hold their last values while OUT_VALID = 0. Verification checks them only when OUT_VALID = 1.
- X-safety: A, B, OP and DEST are ignored when IN_VALID = 0.

## Timing
- Reset (RSTn low, asynchronous): state EMPTY, OUT_VALID = 0, IN_READY = 1, Y = 0, ZERO = 0, DEST_OUT = 0, SK cleared.
- Deassertion of RSTn is synchronised externally. The first accept can occur on the first edge after release.
- Latency: an operation accepted at edge N is presented with OUT_VALID = 1 after edge N (one cycle).
- Throughput: 1 op/cycle while OUT_READY = 1.
- IN_READY depends only on registered state, with no combinational path from OUT_READY. It deasserts the cycle after the second un-drained accept.
- OUT_VALID, Y and DEST_OUT are stable while OUT_VALID = 1 and OUT_READY = 0.
- Reset asserted mid-operation: all entries are lost immediately. Outputs take reset values without waiting for CLK.

## Test plan
- Reset and basic ops:
  - Release RSTn, then apply A = 0xF0F0_1234, B = 0x0FF0_FFFF, DEST = 7.
  - Apply OP = 00, 01, 10, 11 on successive cycles with OUT_READY = 1.
  - Required: Y = 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0x000F_0000, each one cycle after its accept. DEST_OUT = 7. ZERO = 0.
- Zero flag: OP = 00, A = 0xAAAA_AAAA, B = 0x5555_5555 → Y = 0, ZERO = 1. OP = 11, A = B = 0xFFFF_FFFF → Y = 0, ZERO = 1.
- Back-pressure:
  - Hold OUT_READY = 0 and stream 3 ops with DEST = 1, 2, 3.
  - Required: ops 1 and 2 accepted, IN_READY = 0 from the cycle after the 2nd accept, op 3 held upstream.
  - Raise OUT_READY. Required: DEST_OUT order 1, 2, 3, no gaps once streaming.
- FLUSH: fill to TWO, then assert FLUSH with IN_VALID = 1 for one cycle. Required: the next cycle has OUT_VALID = 0 and IN_READY = 1, and the flushed-cycle op never appears at the output.
- Async reset mid-stream: drop RSTn between edges while in TWO. Required: OUT_VALID = 0 and Y = 0 before the next CLK edge. After release, the stage behaves as from cold reset.
- Random soak: 10k cycles of random IN_VALID, OUT_READY, OP and operands, with FLUSH at 1% probability. A reference model checks order, values and ZERO.
